// File: rtl/paicore_hs_pkg.sv
// Shared definitions for the PAICORE handshake responder: widths, channel FSM states and LFSR helpers.
// Optional build macro: PAICORE_HS_ACK_DELAY_EN adds the randomised acknowledge-delay state.
package paicore_hs_pkg;

    localparam int WORD_W  = 32;
    localparam int FRAME_W = 2 * WORD_W;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

`ifdef PAICORE_HS_ACK_DELAY_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        DLY  = 2'd2
    } chan_state_t;
`else
    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } chan_state_t;
`endif

    // Fibonacci step, x^8 + x^6 + x^5 + x^4 + 1 (maximal length)
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/paicore_hs_rx_chan.sv
// One 4-phase request/acknowledge receive channel: captures two 32-bit words into a 64-bit frame.
// Optional build macro: PAICORE_HS_ACK_DELAY_EN inserts an LFSR-driven 0..7 cycle acknowledge wait.
module paicore_hs_rx_chan
    import paicore_hs_pkg::*;
`ifdef PAICORE_HS_ACK_DELAY_EN
#(
    parameter logic [7:0] LFSR_INIT = LFSR_SEED
)
`endif
(
    input  logic               clk,
    input  logic               rst,
    input  logic               request,
    input  logic [WORD_W-1:0]  din,
    output logic               acknowledge,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_valid,
    input  logic               clear
);

    chan_state_t       state_reg, state_next;
    logic              ack_reg, ack_next;
    logic              phase_reg, phase_next;
    logic              fv_reg, fv_next;
    logic [WORD_W-1:0] hi_reg, hi_next;
    logic [WORD_W-1:0] lo_reg, lo_next;
`ifdef PAICORE_HS_ACK_DELAY_EN
    logic [7:0]        lfsr_reg, lfsr_next;
    logic [2:0]        dly_reg, dly_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ack_reg   <= 1'b0;
            phase_reg <= 1'b0;
            fv_reg    <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
`ifdef PAICORE_HS_ACK_DELAY_EN
            lfsr_reg  <= LFSR_INIT;
            dly_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            ack_reg   <= ack_next;
            phase_reg <= phase_next;
            fv_reg    <= fv_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
`ifdef PAICORE_HS_ACK_DELAY_EN
            lfsr_reg  <= lfsr_next;
            dly_reg   <= dly_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        ack_next   = ack_reg;
        phase_next = phase_reg;
        fv_next    = fv_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
`ifdef PAICORE_HS_ACK_DELAY_EN
        lfsr_next  = lfsr_reg;
        dly_next   = dly_reg;
`endif
        if (clear) begin
            fv_next = 1'b0;
        end
        case (state_reg)
            IDLE: begin
                // A held frame blocks the next capture: this is the sender backpressure
                if (request && !fv_reg) begin
                    if (!phase_reg) begin
                        hi_next = din;
                    end else begin
                        lo_next = din;
                    end
`ifdef PAICORE_HS_ACK_DELAY_EN
                    lfsr_next = lfsr_step(lfsr_reg);
                    if (lfsr_reg[2:0] == 3'd0) begin
                        state_next = ACK;
                        ack_next   = 1'b1;
                    end else begin
                        state_next = DLY;
                        dly_next   = lfsr_reg[2:0];
                    end
`else
                    state_next = ACK;
                    ack_next   = 1'b1;
`endif
                end
            end
`ifdef PAICORE_HS_ACK_DELAY_EN
            DLY: begin
                if (dly_reg == 3'd1) begin
                    state_next = ACK;
                    ack_next   = 1'b1;
                end else begin
                    dly_next = dly_reg - 3'd1;
                end
            end
`endif
            ACK: begin
                if (!request) begin
                    state_next = IDLE;
                    ack_next   = 1'b0;
                    phase_next = ~phase_reg;
                    if (phase_reg) begin
                        fv_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                ack_next   = 1'b0;
            end
        endcase
    end

    assign acknowledge = ack_reg;
    assign frame       = {hi_reg, lo_reg};
    assign frame_valid = fv_reg;

endmodule

// File: rtl/paicore_hs_responder.sv
// Multi-channel PAICORE handshake responder: round-robin merge of 64-bit frames onto an AXI-Stream master.
// Optional build macro: PAICORE_HS_ACK_DELAY_EN (randomised acknowledge latency per channel).
module paicore_hs_responder
    import paicore_hs_pkg::*;
#(
    parameter int Channel    = 2,
    parameter int DATA_WIDTH = FRAME_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [Channel-1:0]        request,
    input  logic [Channel*WORD_W-1:0] din,
    output logic [Channel-1:0]        acknowledge,
    input  logic [31:0]               frame_len,
    input  logic                      m_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    output logic [31:0]               frame_cnt,
    output logic                      o_done
);

    localparam int CH_W = (Channel > 1) ? $clog2(Channel) : 1;

    logic [FRAME_W-1:0]    frame_arr [Channel];
    logic [Channel-1:0]    frame_valid;
    logic [Channel-1:0]    clear;

    logic [DATA_WIDTH-1:0] tdata_reg;
    logic                  tvalid_reg;
    logic                  tlast_reg;
    logic [31:0]           beat_reg;
    logic [31:0]           cnt_reg;
    logic                  done_reg;
    logic [CH_W-1:0]       last_grant_reg;

    logic [CH_W-1:0]       grant;
    logic                  grant_found;
    logic                  load_en;
    logic                  load_fire;
    logic                  tlast_calc;
    logic                  beat_accept;

    genvar gi;
    generate
        for (gi = 0; gi < Channel; gi++) begin : g_chan
            paicore_hs_rx_chan
`ifdef PAICORE_HS_ACK_DELAY_EN
            #(
                .LFSR_INIT(LFSR_SEED ^ 8'(gi))
            )
`endif
            u_chan (
                .clk         (clk),
                .rst         (rst),
                .request     (request[gi]),
                .din         (din[WORD_W*gi +: WORD_W]),
                .acknowledge (acknowledge[gi]),
                .frame       (frame_arr[gi]),
                .frame_valid (frame_valid[gi]),
                .clear       (clear[gi])
            );
            assign clear[gi] = load_fire && (grant == CH_W'(gi));
        end
    endgenerate

    // First pending channel after the previous winner, wrapping around
    always_comb begin
        int                 idx;
        logic [Channel-1:0] fv_rot;
        grant       = '0;
        grant_found = 1'b0;
        idx         = 0;
        fv_rot      = '0;
        for (int off = 1; off <= Channel; off++) begin
            idx = int'(last_grant_reg) + off;
            if (idx >= Channel) begin
                idx = idx - Channel;
            end
            fv_rot = frame_valid >> idx;
            if (!grant_found && fv_rot[0]) begin
                grant       = CH_W'(idx);
                grant_found = 1'b1;
            end
        end
    end

    assign load_en     = !tvalid_reg || m_axis_tready;
    assign load_fire   = load_en && grant_found;
    assign beat_accept = tvalid_reg && m_axis_tready;
    assign tlast_calc  = (frame_len != 32'd0) && (beat_reg == frame_len - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            tdata_reg      <= '0;
            tvalid_reg     <= 1'b0;
            tlast_reg      <= 1'b0;
            beat_reg       <= '0;
            // Pointer parked on the last channel so channel 0 is searched first
            last_grant_reg <= CH_W'(Channel - 1);
        end else if (load_fire) begin
            tdata_reg      <= frame_arr[grant];
            tvalid_reg     <= 1'b1;
            tlast_reg      <= tlast_calc;
            beat_reg       <= tlast_calc ? 32'd0 : beat_reg + 32'd1;
            last_grant_reg <= grant;
        end else if (load_en) begin
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            if (beat_accept && (cnt_reg != 32'hFFFF_FFFF)) begin
                cnt_reg <= cnt_reg + 32'd1;
            end
            done_reg <= beat_accept && tlast_reg;
        end
    end

    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tlast  = tlast_reg;
    assign frame_cnt     = cnt_reg;
    assign o_done        = done_reg;

endmodule

// File: tb/tb_paicore_hs_responder.sv
// Directed self-checking bench for paicore_hs_responder (2 channels): handshake latency,
// backpressure, round-robin order, tlast grouping, reset mid-handshake and frame counting.
module tb_paicore_hs_responder;

    localparam int TIMEOUT = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  request = '0;
    logic [63:0] din = '0;
    logic [1:0]  acknowledge;
    logic [31:0] frame_len = '0;
    logic        tready = 1'b0;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic [31:0] frame_cnt;
    logic        o_done;

    int checks = 0;
    int errors = 0;

    logic [64:0] beats[$];
    int          done_cnt = 0;

    paicore_hs_responder #(
        .Channel    (2),
        .DATA_WIDTH (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .request       (request),
        .din           (din),
        .acknowledge   (acknowledge),
        .frame_len     (frame_len),
        .m_axis_tready (tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .frame_cnt     (frame_cnt),
        .o_done        (o_done)
    );

    always #5 clk = ~clk;

    // Accepted beats and done pulses, sampled just before each rising edge
    always begin
        @(negedge clk);
        #4;
        if (m_axis_tvalid && tready) beats.push_back({m_axis_tlast, m_axis_tdata});
        if (o_done) done_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        request = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        beats.delete();
        done_cnt = 0;
    endtask

    task automatic send_word(input logic ch, input logic [31:0] w, output int lat);
        int n;
        din[32*ch +: 32] = w;
        request[ch]      = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!acknowledge[ch] && lat < TIMEOUT);
        if (!acknowledge[ch]) check_eq("ack_rise_timeout", {63'd0, acknowledge[ch]}, 64'd1);
        request[ch] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (acknowledge[ch] && n < TIMEOUT);
        if (acknowledge[ch]) check_eq("ack_fall_timeout", {63'd0, acknowledge[ch]}, 64'd0);
    endtask

    task automatic send_frame(input logic ch, input logic [63:0] f);
        int lat;
        send_word(ch, f[63:32], lat);
        send_word(ch, f[31:0], lat);
    endtask

    initial begin
        int lat;
        logic [63:0] exp_q[$];

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ack", {62'd0, acknowledge}, 64'd0);
        check_eq("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check_eq("rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
        check_eq("rst_tdata", m_axis_tdata, 64'd0);
        check_eq("rst_frame_cnt", {32'd0, frame_cnt}, 64'd0);
        check_eq("rst_done", {63'd0, o_done}, 64'd0);

        // Single frame on ch0, one-beat groups
        frame_len = 32'd1;
        tready    = 1'b1;
        do_reset();
        send_word(1'b0, 32'hDEADBEEF, lat);
        check_eq("t1_lat_hi", 64'(lat), 64'd1);
        send_word(1'b0, 32'h01234567, lat);
        check_eq("t1_lat_lo", 64'(lat), 64'd1);
        repeat (6) @(negedge clk);
        check_eq("t1_nbeats", 64'(beats.size()), 64'd1);
        if (beats.size() > 0) begin
            check_eq("t1_data", beats[0][63:0], 64'hDEADBEEF01234567);
            check_eq("t1_last", {63'd0, beats[0][64]}, 64'd1);
        end
        check_eq("t1_frame_cnt", {32'd0, frame_cnt}, 64'd1);
        check_eq("t1_done", 64'(done_cnt), 64'd1);

        // Backpressure: output stalled, both channels queue frames
        frame_len = 32'd0;
        tready    = 1'b0;
        do_reset();
        send_frame(1'b0, 64'hA0A0A0A0_00000001);
        send_frame(1'b0, 64'hB0B0B0B0_00000002);
        send_frame(1'b1, 64'hA1A1A1A1_00000003);
        fork
            send_frame(1'b1, 64'hB1B1B1B1_00000004);
            begin
                repeat (6) @(negedge clk);
                check_eq("t2_ch1_stall", {63'd0, acknowledge[1]}, 64'd0);
                check_eq("t2_hold_valid", {63'd0, m_axis_tvalid}, 64'd1);
                check_eq("t2_hold_data", m_axis_tdata, 64'hA0A0A0A0_00000001);
                tready = 1'b1;
            end
        join
        repeat (8) @(negedge clk);
        exp_q = '{64'hA0A0A0A0_00000001, 64'hA1A1A1A1_00000003,
                  64'hB0B0B0B0_00000002, 64'hB1B1B1B1_00000004};
        check_eq("t2_nbeats", 64'(beats.size()), 64'd4);
        for (int i = 0; i < 4 && i < beats.size(); i++)
            check_eq($sformatf("t2_beat%0d", i), beats[i][63:0], exp_q[i]);
        check_eq("t2_frame_cnt", {32'd0, frame_cnt}, 64'd4);

        // Groups of three beats on ch1
        frame_len = 32'd3;
        do_reset();
        for (int i = 0; i < 6; i++) send_frame(1'b1, {32'hC0DE0000 + 32'(i), 32'(i)});
        repeat (6) @(negedge clk);
        check_eq("t3_nbeats", 64'(beats.size()), 64'd6);
        for (int i = 0; i < 6 && i < beats.size(); i++) begin
            check_eq($sformatf("t3_last%0d", i), {63'd0, beats[i][64]}, (i % 3 == 2) ? 64'd1 : 64'd0);
            check_eq($sformatf("t3_data%0d", i), beats[i][63:0], {32'hC0DE0000 + 32'(i), 32'(i)});
        end
        check_eq("t3_done", 64'(done_cnt), 64'd2);
        check_eq("t3_frame_cnt", {32'd0, frame_cnt}, 64'd6);

        // Reset while ch0 holds acknowledge after the hi word
        frame_len = 32'd0;
        do_reset();
        din[31:0]  = 32'hAAAA0000;
        request[0] = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!acknowledge[0] && lat < TIMEOUT);
        check_eq("t4_ack_before_rst", {63'd0, acknowledge[0]}, 64'd1);
        rst        = 1'b1;
        request[0] = 1'b0;
        @(negedge clk);
        check_eq("t4_ack_after_rst", {63'd0, acknowledge[0]}, 64'd0);
        rst = 1'b0;
        beats.delete();
        done_cnt = 0;
        send_frame(1'b0, 64'h11111111_22222222);
        repeat (6) @(negedge clk);
        check_eq("t4_nbeats", 64'(beats.size()), 64'd1);
        if (beats.size() > 0) check_eq("t4_data", beats[0][63:0], 64'h11111111_22222222);

        // Simultaneous completion with ch1 as the previous winner
        do_reset();
        send_frame(1'b1, 64'h5A5A5A5A_00000010);
        repeat (4) @(negedge clk);
        fork
            send_frame(1'b0, 64'h00C0FFEE_00000020);
            send_frame(1'b1, 64'h11C0FFEE_00000030);
        join
        repeat (6) @(negedge clk);
        check_eq("t5_nbeats", 64'(beats.size()), 64'd3);
        if (beats.size() > 2) begin
            check_eq("t5_first", beats[1][63:0], 64'h00C0FFEE_00000020);
            check_eq("t5_second", beats[2][63:0], 64'h11C0FFEE_00000030);
        end

        // frame_len = 0: no grouping
        frame_len = 32'd0;
        do_reset();
        for (int i = 0; i < 5; i++) send_frame(1'b0, {32'h0F0F0000 + 32'(i), 32'hFFFF0000 + 32'(i)});
        repeat (6) @(negedge clk);
        check_eq("t6_nbeats", 64'(beats.size()), 64'd5);
        for (int i = 0; i < 5 && i < beats.size(); i++)
            check_eq($sformatf("t6_last%0d", i), {63'd0, beats[i][64]}, 64'd0);
        check_eq("t6_done", 64'(done_cnt), 64'd0);
        check_eq("t6_frame_cnt", {32'd0, frame_cnt}, 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
